gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
Hardware stimulus generator and response checker for a 2-input combinational gate. It is the in-silicon counterpart of the truth-table bench: it drives all four input vectors to the gate under test, waits for a settle window, samples the gate output and compares it against an expected truth table. It reports pass/fail, an error count and a per-vector fail map, and sits beside a gate instance as a built-in self-test.

Parameters:
SETTLE_CYCLES, 2, cycles between stimulus application and sampling; 0 is legal (no settle window)
EXPECT_TT, 4'b1000, expected y per vector index {a,b}; bit i is the expected y for vector i; the default is AND
ERR_W, 3, width of err_count; must be >= 1

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  begin a test run; sampled in IDLE only
a_out  output  1  stimulus to gate input a (registered)
b_out  output  1  stimulus to gate input b (registered)
y_in  input  1  gate output under test
busy  output  1  high while a run is in progress
done  output  1  high from run completion until the next accepted start
pass  output  1  valid when done=1; 1 if err_count==0
err_count  output  ERR_W  number of mismatching vectors; saturates at 2^ERR_W-1
fail_vec  output  4  bit i set if vector i mismatched

Behaviour:
- Reset: one clock, reset is synchronous and active-low (clk, rst_n). A rising edge with rst_n=0 forces the following: state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vec=0, settle counter=0. Reset wins over every other event, including a reset mid-run, and any partial results are discarded.
- Vector order: vec 0..3 with {a_out,b_out}=vec, giving 00, 01, 10, 11.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge: go to APPLY and in the same edge set vec=0, {a_out,b_out}=00, busy=1, done=0, pass=0, err_count=0, fail_vec=0.
  - Otherwise hold all outputs, so a previous done/pass/err result stays visible.
- APPLY: one cycle. Stimulus is stable. Load the settle counter with SETTLE_CYCLES. Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
- SETTLE: decrement the counter each cycle. When it reaches 1, go to SAMPLE. The state lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: one cycle. On its closing edge, compare y_in with EXPECT_TT[vec].
  - On a mismatch: fail_vec[vec]<=1, and err_count<=err_count+1 unless it is already all-ones (saturate).
  - If vec<3: vec<=vec+1, update {a_out,b_out} to the new vec, go to APPLY.
  - If vec==3: go to DONE, set busy=0, done=1, and pass=1 only if there was no mismatch, including the final compare. The final compare result must be folded into pass on this same edge.
- DONE: one cycle. {a_out,b_out}<=00, then go to IDLE. done, pass, err_count and fail_vec hold.
- Latency: each vector takes SETTLE_CYCLES+2 cycles. With the start edge as edge 0, done is visible after edge 4*(SETTLE_CYCLES+2): edge 16 for the default, edge 8 for SETTLE_CYCLES=0.
- start is ignored while busy=1 and in DONE. start held high continuously re-triggers a run from IDLE.
- y_in is sampled only in SAMPLE. Glitches elsewhere have no effect.
- X/Z on y_in counts as a mismatch; the compare uses case-inequality.
- No combinational path from any input to any output.

Test Plan:
- Ideal AND gate on a_out/b_out→y_in, pulse start → a_out/b_out sequence 00,01,10,11, each held 4 cycles; done=1 after edge 16; pass=1, err_count=0, fail_vec=0000.
- y_in stuck at 0 → done at edge 16, pass=0, err_count=1, fail_vec=1000. y_in stuck at 1 → err_count=3, fail_vec=0111.
- OR gate as the DUT with default EXPECT_TT → err_count=2, fail_vec=0110. Rerun with EXPECT_TT=4'b1110 → pass=1.
- start pulsed again while busy → no restart and identical result. After done, a new start → done/pass/err_count/fail_vec clear on the start edge and the run repeats.
- rst_n=0 for one edge during vec 2 with a stuck-at-1 DUT → all outputs 0 next cycle and state IDLE. A new start restarts at vector 00, giving final err_count=3.
- SETTLE_CYCLES=0, ERR_W=1, stuck-at-1 DUT → done after edge 8, err_count saturates at 1, fail_vec=0111, pass=0.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test controller for a 2-input combinational gate.
// Walks the four input vectors 00,01,10,11 onto a_out/b_out and waits a settle
// window after each one. It then samples y_in and compares it against
// EXPECT_TT. Reports pass/fail, a saturating error count and a per-vector
// fail map. Every output is a register, so no input reaches an output
// combinationally.
module gate_bist_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT_TT     = 4'b1000,
  parameter int         ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam bit HAS_SETTLE = (SETTLE_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       vec, vec_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [3:0]       fv_nxt;
  logic             mismatch;

  // State and result registers; reset discards any partial run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vec       <= '0;
      cnt       <= '0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      cnt       <= cnt_nxt;
      a_out     <= a_nxt;
      b_out     <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
      fail_vec  <= fv_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a state moves it
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    a_nxt     = a_out;
    b_nxt     = b_out;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_count;
    fv_nxt    = fail_vec;
    // Case-inequality so that an X/Z on y_in counts as a failure
    mismatch  = (y_in !== EXPECT_TT[vec]);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_APPLY;
          vec_nxt   = 2'd0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = '0;
          fv_nxt    = '0;
        end
      end
      S_APPLY: begin
        cnt_nxt   = CNT_W'(SETTLE_CYCLES);
        state_nxt = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
      end
      S_SETTLE: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          fv_nxt[vec] = 1'b1;
          if (!(&err_count)) err_nxt = err_count + ERR_W'(1);
        end
        if (vec != 2'd3) begin
          vec_nxt          = vec + 2'd1;
          {a_nxt, b_nxt}   = vec + 2'd1;
          state_nxt        = S_APPLY;
        end else begin
          // Final compare is folded in through fv_nxt on this same edge
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (fv_nxt == 4'd0);
        end
      end
      S_DONE: begin
        a_nxt     = 1'b0;
        b_nxt     = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three instances (default, OR truth table,
// zero settle with 1-bit error count), each driving a modelled gate whose
// truth table the bench chooses per run.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start;
  logic [3:0] gtt [3];
  logic [2:0] a_w, b_w, y_w, busy_w, done_w, pass_w;
  logic [2:0] err0, err1;
  logic       err2;
  logic [3:0] fv0, fv1, fv2;

  int checks = 0;
  int errors = 0;

  // Gate models: y is the chosen truth table indexed by {a,b}
  assign y_w[0] = gtt[0][{a_w[0], b_w[0]}];
  assign y_w[1] = gtt[1][{a_w[1], b_w[1]}];
  assign y_w[2] = gtt[2][{a_w[2], b_w[2]}];

  gate_bist_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_out(a_w[0]), .b_out(b_w[0]),
    .y_in(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err0), .fail_vec(fv0));

  gate_bist_ctrl #(.EXPECT_TT(4'b1110)) u_or (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_out(a_w[1]), .b_out(b_w[1]),
    .y_in(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err1), .fail_vec(fv1));

  gate_bist_ctrl #(.SETTLE_CYCLES(0), .ERR_W(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a_out(a_w[2]), .b_out(b_w[2]),
    .y_in(y_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err2), .fail_vec(fv2));

  function automatic int settle_of(input int i);
    return (i == 2) ? 0 : 2;
  endfunction

  function automatic logic [3:0] exp_tt_of(input int i);
    return (i == 1) ? 4'b1110 : 4'b1000;
  endfunction

  function automatic int errw_of(input int i);
    return (i == 2) ? 1 : 3;
  endfunction

  function automatic int err_of(input int i);
    case (i)
      0:       return int'(err0);
      1:       return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  function automatic logic [3:0] fv_of(input int i);
    case (i)
      0:       return fv0;
      1:       return fv1;
      default: return fv2;
    endcase
  endfunction

  // Reference: mismatches are the XOR of actual and expected tables
  function automatic void model(input logic [3:0] g, input int i,
                                output logic [3:0] fv, output int err, output bit p);
    int cap;
    fv  = g ^ exp_tt_of(i);
    err = 0;
    for (int k = 0; k < 4; k++) err += int'(fv[k]);
    cap = (1 << errw_of(i)) - 1;
    if (err > cap) err = cap;
    p = (fv == 4'd0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_result(input string nm, input int i, input logic [3:0] efv,
                            input int eerr, input bit ep);
    chk({nm, "_done"}, 32'(done_w[i]), 32'd1);
    chk({nm, "_busy"}, 32'(busy_w[i]), 32'd0);
    chk({nm, "_pass"}, 32'(pass_w[i]), 32'(ep));
    chk({nm, "_err"},  32'(err_of(i)), 32'(eerr));
    chk({nm, "_fv"},   32'(fv_of(i)),  32'(efv));
  endtask

  // One full run from the start edge; optional start pulses while busy / in DONE
  task automatic run_check(input int i, input logic [3:0] g, input logic [3:0] efv,
                           input int eerr, input bit ep, input string nm,
                           input int pulse_busy, input bit pulse_done);
    int per, tlen;
    per  = settle_of(i) + 2;
    tlen = 4 * per;
    gtt[i]   = g;
    start[i] = 1'b1;
    @(negedge clk);                 // edge 0 has accepted start
    start[i] = 1'b0;
    chk({nm, "_st_busy"}, 32'(busy_w[i]), 32'd1);
    chk({nm, "_st_done"}, 32'(done_w[i]), 32'd0);
    chk({nm, "_st_pass"}, 32'(pass_w[i]), 32'd0);
    chk({nm, "_st_err"},  32'(err_of(i)), 32'd0);
    chk({nm, "_st_fv"},   32'(fv_of(i)),  32'd0);
    for (int k = 0; k < tlen; k++) begin
      chk($sformatf("%s_ab_e%0d", nm, k), 32'({a_w[i], b_w[i]}), 32'(k / per));
      chk($sformatf("%s_done_e%0d", nm, k), 32'(done_w[i]), 32'd0);
      start[i] = (k == pulse_busy);
      @(negedge clk);
    end
    start[i] = 1'b0;
    chk_result({nm, "_end"}, i, efv, eerr, ep);
    chk({nm, "_end_ab"}, 32'({a_w[i], b_w[i]}), 32'd3);
    start[i] = pulse_done;
    @(negedge clk);                 // DONE state closed
    start[i] = 1'b0;
    chk_result({nm, "_post"}, i, efv, eerr, ep);
    chk({nm, "_post_ab"}, 32'({a_w[i], b_w[i]}), 32'd0);
    @(negedge clk);                 // idle: result must still be held
    chk_result({nm, "_idle"}, i, efv, eerr, ep);
  endtask

  typedef struct {
    int         inst;
    logic [3:0] g;
    logic [3:0] fv;
    int         err;
    bit         p;
    string      nm;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [3:0] mfv;
    int         merr;
    bit         mp;
    int         ri;
    logic [3:0] rg;

    tbl[0] = '{0, 4'b1000, 4'b0000, 0, 1'b1, "and"};
    tbl[1] = '{0, 4'b0000, 4'b1000, 1, 1'b0, "stuck0"};
    tbl[2] = '{0, 4'b1111, 4'b0111, 3, 1'b0, "stuck1"};
    tbl[3] = '{0, 4'b1110, 4'b0110, 2, 1'b0, "or_vs_and"};
    tbl[4] = '{1, 4'b1110, 4'b0000, 0, 1'b1, "or_vs_or"};
    tbl[5] = '{2, 4'b1111, 4'b0111, 1, 1'b0, "fast_stuck1"};
    tbl[6] = '{2, 4'b1000, 4'b0000, 0, 1'b1, "fast_and"};

    rst_n = 1'b0;
    start = 3'b000;
    for (int i = 0; i < 3; i++) gtt[i] = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
      chk($sformatf("rst_pass%0d", i), 32'(pass_w[i]), 32'd0);
      chk($sformatf("rst_ab%0d", i), 32'({a_w[i], b_w[i]}), 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(err_of(i)), 32'd0);
      chk($sformatf("rst_fv%0d", i), 32'(fv_of(i)), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int t = 0; t < 7; t++)
      run_check(tbl[t].inst, tbl[t].g, tbl[t].fv, tbl[t].err, tbl[t].p, tbl[t].nm, -1, 1'b0);

    // Start pulses while busy and in DONE must not disturb the run
    run_check(0, 4'b0000, 4'b1000, 1, 1'b0, "pulse_busy", 5, 1'b1);
    run_check(0, 4'b0000, 4'b1000, 1, 1'b0, "pulse_late", 14, 1'b0);
    // A new start after a failing run clears the results and repeats
    run_check(0, 4'b1000, 4'b0000, 0, 1'b1, "rerun_and", -1, 1'b0);

    // Reset in the middle of vector 2 with a stuck-at-1 gate
    gtt[0]   = 4'b1111;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_ab_before_rst", 32'({a_w[0], b_w[0]}), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_rst_done", 32'(done_w[0]), 32'd0);
    chk("mid_rst_pass", 32'(pass_w[0]), 32'd0);
    chk("mid_rst_ab",   32'({a_w[0], b_w[0]}), 32'd0);
    chk("mid_rst_err",  32'(err_of(0)), 32'd0);
    chk("mid_rst_fv",   32'(fv_of(0)), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_idle_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_idle_ab",   32'({a_w[0], b_w[0]}), 32'd0);
    run_check(0, 4'b1111, 4'b0111, 3, 1'b0, "after_rst", -1, 1'b0);

    // start held high re-triggers from IDLE (zero-settle instance, 8-edge run)
    gtt[2]   = 4'b1111;
    start[2] = 1'b1;
    @(negedge clk);                 // edge 0
    repeat (8) @(negedge clk);      // edge 8
    chk("hold_done_e8", 32'(done_w[2]), 32'd1);
    @(negedge clk);                 // edge 9: DONE -> IDLE
    chk("hold_done_e9", 32'(done_w[2]), 32'd1);
    @(negedge clk);                 // edge 10: start accepted again
    chk("hold_done_e10", 32'(done_w[2]), 32'd0);
    chk("hold_busy_e10", 32'(busy_w[2]), 32'd1);
    start[2] = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_final_err", 32'(err_of(2)), 32'd1);
    chk("hold_final_fv",  32'(fv_of(2)), 32'b0111);

    // Randomized gate truth tables against the reference model
    for (int r = 0; r < 10; r++) begin
      ri = int'($urandom_range(0, 2));
      rg = 4'($urandom);
      model(rg, ri, mfv, merr, mp);
      run_check(ri, rg, mfv, merr, mp, $sformatf("rnd%0d_i%0d_g%0h", r, ri, rg), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
